// File: rtl/fb_ctrl_pkg.sv
// Shared types and constants for the framebuffer port-A fill engine and arbiter.
package fb_ctrl_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 12;
    localparam int FB_DEPTH  = 76800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/fb_fill_arbiter_if.sv
// Bundle of fill-configuration, CPU and BRAM port-A signals around the fill arbiter.
interface fb_fill_arbiter_if #(
    parameter int ADDR_W = fb_ctrl_pkg::FB_ADDR_W,
    parameter int DATA_W = fb_ctrl_pkg::FB_DATA_W
);
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_count;
    logic [DATA_W-1:0] cfg_color;
    logic              busy;
    logic              done;
    logic              cpu_req;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_stall;
    logic              fb_wena;
    logic [ADDR_W-1:0] fb_addra;
    logic [DATA_W-1:0] fb_dina;
    logic [DATA_W-1:0] fb_douta;

    // slave: the arbiter itself; master: the memory stage, config block and BRAM around it
    modport slave (
        input  cfg_start, cfg_base, cfg_count, cfg_color,
        input  cpu_req, cpu_wen, cpu_addr, cpu_din, fb_douta,
        output busy, done, cpu_dout, cpu_stall, fb_wena, fb_addra, fb_dina
    );

    modport master (
        output cfg_start, cfg_base, cfg_count, cfg_color,
        output cpu_req, cpu_wen, cpu_addr, cpu_din, fb_douta,
        input  busy, done, cpu_dout, cpu_stall, fb_wena, fb_addra, fb_dina
    );

endinterface

// File: rtl/fb_fill_addr_gen.sv
// Fill address generator: clamps the requested range to the framebuffer and walks it.
module fb_fill_addr_gen #(
    parameter int ADDR_W   = fb_ctrl_pkg::FB_ADDR_W,
    parameter int FB_DEPTH = fb_ctrl_pkg::FB_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_count,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              last,
    output logic              eff_zero
);

    localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_V  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_V   = ADDR_W'(1'b1);

    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] remaining_r;
    logic [ADDR_W-1:0] avail_s;
    logic [ADDR_W-1:0] eff_s;

    // Effective length: never run past the last framebuffer word
    always_comb begin
        avail_s = ZERO_V;
        eff_s   = ZERO_V;
        if (cfg_base >= DEPTH_V) begin
            eff_s = ZERO_V;
        end else begin
            avail_s = DEPTH_V - cfg_base;
            if (cfg_count < avail_s) begin
                eff_s = cfg_count;
            end else begin
                eff_s = avail_s;
            end
        end
    end

    // Current address and words remaining
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_addr_r  <= ZERO_V;
            remaining_r <= ZERO_V;
        end else if (load) begin
            cur_addr_r  <= cfg_base;
            remaining_r <= eff_s;
        end else if (advance) begin
            cur_addr_r  <= cur_addr_r + ONE_V;
            remaining_r <= remaining_r - ONE_V;
        end else begin
            cur_addr_r  <= cur_addr_r;
            remaining_r <= remaining_r;
        end
    end

    assign cur_addr = cur_addr_r;
    assign last     = (remaining_r == ONE_V);
    assign eff_zero = (eff_s == ZERO_V);

endmodule

// File: rtl/fb_fill_arbiter.sv
// Framebuffer port-A fill engine: CPU-priority arbitration with a bounded-starvation
// guarantee so a background colour fill always makes progress.
module fb_fill_arbiter #(
    parameter int ADDR_W     = fb_ctrl_pkg::FB_ADDR_W,
    parameter int DATA_W     = fb_ctrl_pkg::FB_DATA_W,
    parameter int FB_DEPTH   = fb_ctrl_pkg::FB_DEPTH,
    parameter int STARVE_MAX = 8
) (
    input  logic            clock,
    input  logic            reset,
    fb_fill_arbiter_if.slave bus
);
    import fb_ctrl_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1'b1);

    fill_state_e       state_r;
    logic [SW-1:0]     starve_cnt_r;
    logic [DATA_W-1:0] color_r;
    logic              busy_r;
    logic              done_r;

    logic              fill_grant_s;
    logic              load_s;
    logic              last_s;
    logic              eff_zero_s;
    logic [ADDR_W-1:0] cur_addr_s;

    fb_fill_addr_gen #(
        .ADDR_W   (ADDR_W),
        .FB_DEPTH (FB_DEPTH)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .load      (load_s),
        .advance   (fill_grant_s),
        .cfg_base  (bus.cfg_base),
        .cfg_count (bus.cfg_count),
        .cur_addr  (cur_addr_s),
        .last      (last_s),
        .eff_zero  (eff_zero_s)
    );

    // Fill wins when the CPU is quiet or has starved it for STARVE_MAX cycles
    always_comb begin
        fill_grant_s = 1'b0;
        load_s       = 1'b0;
        if (state_r == FILL) begin
            fill_grant_s = !bus.cpu_req || (starve_cnt_r == STARVE_LIM);
        end else begin
            fill_grant_s = 1'b0;
        end
        if (state_r == IDLE) begin
            load_s = bus.cfg_start;
        end else begin
            load_s = 1'b0;
        end
    end

    // Port-A mux: CPU passthrough unless the fill owns this cycle
    always_comb begin
        bus.fb_wena   = 1'b0;
        bus.fb_addra  = bus.cpu_addr;
        bus.fb_dina   = bus.cpu_din;
        bus.cpu_stall = 1'b0;
        if (reset) begin
            bus.fb_wena   = 1'b0;
            bus.cpu_stall = 1'b0;
        end else if (fill_grant_s) begin
            bus.fb_wena   = 1'b1;
            bus.fb_addra  = cur_addr_s;
            bus.fb_dina   = color_r;
            bus.cpu_stall = bus.cpu_req;
        end else begin
            bus.fb_wena   = bus.cpu_req & bus.cpu_wen;
            bus.cpu_stall = 1'b0;
        end
    end

    // Control FSM with starvation counter and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            starve_cnt_r <= {SW{1'b0}};
            color_r      <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    starve_cnt_r <= {SW{1'b0}};
                    if (bus.cfg_start) begin
                        color_r <= bus.cfg_color;
                        busy_r  <= 1'b1;
                        if (eff_zero_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= FILL;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                FILL: begin
                    if (fill_grant_s) begin
                        starve_cnt_r <= {SW{1'b0}};
                        if (last_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= FILL;
                        end
                    end else if (bus.cpu_req && (starve_cnt_r != STARVE_LIM)) begin
                        starve_cnt_r <= starve_cnt_r + STARVE_ONE;
                    end else begin
                        starve_cnt_r <= starve_cnt_r;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    starve_cnt_r <= {SW{1'b0}};
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.cpu_dout = bus.fb_douta;

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Directed bench for fb_fill_arbiter: per-cycle vector table plus multi-cycle sequences
// against a behavioural one-cycle-latency BRAM.
module tb_fb_fill_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 76800;

    typedef struct {
        logic          start;
        logic [AW-1:0] base;
        logic [AW-1:0] count;
        logic [DW-1:0] color;
        logic          req;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          e_wena;
        logic [AW-1:0] e_addra;
        logic [DW-1:0] e_dina;
        logic          e_stall;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    logic clock;
    logic reset;
    int   errors;
    int   checks;
    logic [DW-1:0] mem [0:DEPTH-1];
    vec_t vecs [0:23];

    fb_fill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_fill_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FB_DEPTH   (DEPTH),
        .STARVE_MAX (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural BRAM port A, one-cycle read latency
    always @(posedge clock) begin
        if (bus.fb_addra < AW'(DEPTH)) begin
            if (bus.fb_wena) mem[bus.fb_addra] <= bus.fb_dina;
            bus.fb_douta <= mem[bus.fb_addra];
        end else begin
            bus.fb_douta <= '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic wen, input logic [AW-1:0] addr,
                           input logic [DW-1:0] din);
        bus.cpu_req  = req;
        bus.cpu_wen  = wen;
        bus.cpu_addr = addr;
        bus.cpu_din  = din;
    endtask

    task automatic set_cfg(input logic start, input logic [AW-1:0] base,
                           input logic [AW-1:0] count, input logic [DW-1:0] color);
        bus.cfg_start = start;
        bus.cfg_base  = base;
        bus.cfg_count = count;
        bus.cfg_color = color;
    endtask

    function automatic vec_t mk(input logic start, input int base, input int count, input int color,
                                input logic req, input logic wen, input int addr, input int din,
                                input logic e_wena, input int e_addra, input int e_dina,
                                input logic e_stall, input logic e_busy, input logic e_done);
        vec_t v;
        v.start = start;   v.base = AW'(base);       v.count = AW'(count);  v.color = DW'(color);
        v.req = req;       v.wen = wen;              v.addr = AW'(addr);    v.din = DW'(din);
        v.e_wena = e_wena; v.e_addra = AW'(e_addra); v.e_dina = DW'(e_dina);
        v.e_stall = e_stall; v.e_busy = e_busy;      v.e_done = e_done;
        return v;
    endfunction

    initial begin
        int writes;
        int dones;
        errors = 0;
        checks = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.fb_douta = '0;

        // Uncontended fill 0x10..0x13
        vecs[0]  = mk(1'b1, 'h10, 4, 'hF00, 1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b1, 'h10, 'hF00, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b1, 'h11, 'hF00, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b1, 'h12, 'hF00, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b1, 'h13, 'hF00, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b1, 1'b1);
        vecs[6]  = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b0, 1'b0);
        // CPU write wins mid-fill; start during DONE ignored
        vecs[7]  = mk(1'b1, 'h20, 2, 'h0A5, 1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 0, 0, 0,  1'b1, 1'b1, 'h200, 'h123, 1'b1, 'h200, 'h123, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b1, 'h20, 'h0A5, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b1, 'h21, 'h0A5, 1'b0, 1'b1, 1'b0);
        vecs[11] = mk(1'b1, 'h40, 1, 'hEEE, 1'b1, 1'b1, 'h300, 'h456, 1'b1, 'h300, 'h456, 1'b0, 1'b1, 1'b1);
        vecs[12] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b0, 1'b0);
        // Zero count
        vecs[13] = mk(1'b1, 'h50, 0, 'h999, 1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b1, 1'b1);
        vecs[15] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b0, 1'b0);
        // Clamp at the end of the framebuffer
        vecs[16] = mk(1'b1, 76798, 10, 'h777, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b1, 76798, 'h777, 1'b0, 1'b1, 1'b0);
        vecs[18] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b1, 76799, 'h777, 1'b0, 1'b1, 1'b0);
        vecs[19] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b1, 1'b1);
        vecs[20] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b0, 1'b0);
        // Base beyond the framebuffer
        vecs[21] = mk(1'b1, 80000, 5, 'h222, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0);
        vecs[22] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b1, 1'b1);
        vecs[23] = mk(1'b0, 0, 0, 0,        1'b0, 1'b0, 0, 0,  1'b0, 0, 0,  1'b0, 1'b0, 1'b0);

        // Reset state, with a CPU write request present
        reset = 1'b1;
        set_cfg(1'b0, '0, '0, '0);
        set_cpu(1'b1, 1'b1, AW'('h123), DW'('h321));
        #2;
        chk("rst_wena", 32'(bus.fb_wena), 32'd0);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_addra", 32'(bus.fb_addra), 32'h123);
        chk("rst_dina", 32'(bus.fb_dina), 32'h321);
        next_cycle();
        next_cycle();
        set_cpu(1'b0, 1'b0, '0, '0);
        reset = 1'b0;

        // Idle passthrough: write then read back
        set_cpu(1'b1, 1'b1, AW'('h100), DW'('hABC));
        #3;
        chk("pt_wr_wena", 32'(bus.fb_wena), 32'd1);
        chk("pt_wr_stall", 32'(bus.cpu_stall), 32'd0);
        next_cycle();
        set_cpu(1'b1, 1'b0, AW'('h100), DW'('h000));
        #3;
        chk("pt_rd_wena", 32'(bus.fb_wena), 32'd0);
        chk("pt_rd_stall", 32'(bus.cpu_stall), 32'd0);
        next_cycle();
        set_cpu(1'b0, 1'b0, '0, '0);
        #3;
        chk("pt_rd_dout", 32'(bus.cpu_dout), 32'hABC);
        next_cycle();

        // Table of single-cycle vectors
        for (int i = 0; i < 24; i++) begin
            set_cfg(vecs[i].start, vecs[i].base, vecs[i].count, vecs[i].color);
            set_cpu(vecs[i].req, vecs[i].wen, vecs[i].addr, vecs[i].din);
            #3;
            chk($sformatf("v%0d_wena", i), 32'(bus.fb_wena), 32'(vecs[i].e_wena));
            chk($sformatf("v%0d_addra", i), 32'(bus.fb_addra), 32'(vecs[i].e_addra));
            chk($sformatf("v%0d_dina", i), 32'(bus.fb_dina), 32'(vecs[i].e_dina));
            chk($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(vecs[i].e_done));
            next_cycle();
        end
        set_cfg(1'b0, '0, '0, '0);
        set_cpu(1'b0, 1'b0, '0, '0);
        chk("mem_0x13", 32'(mem['h13]), 32'hF00);
        chk("mem_0x200", 32'(mem['h200]), 32'h123);
        chk("mem_76799", 32'(mem[76799]), 32'h777);

        // Starvation: continuous CPU reads, fill of 3 words gets every 9th cycle
        set_cfg(1'b1, AW'('h700), AW'(3), DW'('h5A5));
        set_cpu(1'b1, 1'b0, AW'('h100), DW'('h000));
        next_cycle();
        set_cfg(1'b0, '0, '0, '0);
        writes = 0;
        for (int k = 1; k <= 27; k++) begin
            #3;
            chk($sformatf("sv_stall_k%0d", k), 32'(bus.cpu_stall), 32'((k % 9) == 0));
            if (bus.fb_wena) begin
                writes++;
                chk($sformatf("sv_addr_k%0d", k), 32'(bus.fb_addra), 32'h700 + 32'(writes - 1));
            end
            if (k == 2) chk("sv_cpu_dout", 32'(bus.cpu_dout), 32'hABC);
            next_cycle();
        end
        chk("sv_writes", 32'(writes), 32'd3);
        #3;
        chk("sv_done", 32'(bus.done), 32'd1);
        set_cpu(1'b0, 1'b0, '0, '0);
        next_cycle();
        #3;
        chk("sv_busy_off", 32'(bus.busy), 32'd0);
        chk("sv_mem_last", 32'(mem['h702]), 32'h5A5);
        next_cycle();

        // Reset in the middle of an 8-word fill
        set_cfg(1'b1, AW'('h400), AW'(8), DW'('hBBB));
        next_cycle();
        set_cfg(1'b0, '0, '0, '0);
        #3;
        chk("rm_w0", 32'(bus.fb_addra), 32'h400);
        next_cycle();
        #3;
        chk("rm_w1", 32'(bus.fb_addra), 32'h401);
        next_cycle();
        set_cpu(1'b1, 1'b1, AW'('h10), DW'('h0));
        reset = 1'b1;
        #1;
        chk("rm_busy", 32'(bus.busy), 32'd0);
        chk("rm_wena", 32'(bus.fb_wena), 32'd0);
        chk("rm_stall", 32'(bus.cpu_stall), 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        set_cpu(1'b0, 1'b0, '0, '0);
        writes = 0;
        dones  = 0;
        for (int k = 0; k < 12; k++) begin
            #3;
            if (bus.fb_wena) writes++;
            if (bus.done) dones++;
            next_cycle();
        end
        chk("rm_no_writes", 32'(writes), 32'd0);
        chk("rm_no_done", 32'(dones), 32'd0);
        chk("rm_mem", 32'(mem['h402]), 32'h000);

        // Second start during FILL is ignored
        set_cfg(1'b1, AW'('h500), AW'(3), DW'('h3C3));
        next_cycle();
        set_cfg(1'b1, AW'('h600), AW'(3), DW'('h111));
        for (int k = 0; k < 3; k++) begin
            #3;
            chk($sformatf("sb_wena%0d", k), 32'(bus.fb_wena), 32'd1);
            chk($sformatf("sb_addr%0d", k), 32'(bus.fb_addra), 32'h500 + 32'(k));
            chk($sformatf("sb_dina%0d", k), 32'(bus.fb_dina), 32'h3C3);
            next_cycle();
            set_cfg(1'b0, '0, '0, '0);
        end
        #3;
        chk("sb_done", 32'(bus.done), 32'd1);
        next_cycle();
        #3;
        chk("sb_idle", 32'(bus.busy), 32'd0);
        chk("sb_mem_600", 32'(mem['h600]), 32'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
